lopd_norm_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational leading-one position detector (LOPD).
- Finds the leading-one or trailing-one position of a SIZE_DATA-bit word, selected per transaction.
- Produces the normalising shift amount and the normalised word.
- Sits in the floating-point add/normalise datapath behind a valid/ready stream interface with full backpressure.

---
 rtl/lopd_pkg.sv | 12 +
 rtl/lopd_prio_enc.sv | 26 ++
 rtl/lopd_norm_pipe.sv | 164 ++++++++++++++++
 tb/tb_lopd_norm_pipe.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lopd_pkg.sv
// Shared types and defaults for the pipelined leading/trailing-one detector.
// Mode encoding matches the single-bit i_mode port directly.
package lopd_pkg;

  typedef enum logic {
    LOPD_LEAD  = 1'b0,
    LOPD_TRAIL = 1'b1
  } lopd_mode_e;

  localparam int LOPD_SIZE_DATA = 24;

endpackage

// File: rtl/lopd_prio_enc.sv
// Combinational MSB-first priority encoder: index of the highest set bit plus an
// all-zero flag. Position reads 0 for an all-zero word.
module lopd_prio_enc
  import lopd_pkg::*;
#(
  parameter int SIZE_DATA = LOPD_SIZE_DATA,
  parameter int SIZE_LOPD = $clog2(SIZE_DATA)
) (
  input  logic [SIZE_DATA-1:0] data_i,
  output logic [SIZE_LOPD-1:0] pos_o,
  output logic                 zero_o
);

  // Ascending scan, so the highest set bit is the last to write pos_o.
  always_comb begin
    pos_o = '0;
    for (int i = 0; i < SIZE_DATA; i++) begin
      if (data_i[i]) begin
        pos_o = SIZE_LOPD'(i);
      end
    end
  end

  assign zero_o = ~|data_i;

endmodule

// File: rtl/lopd_norm_pipe.sv
// Two-stage leading/trailing-one detector and normaliser behind a valid/ready stream.
// S1 locates the one; S2 derives the shift amount and normalised word.
module lopd_norm_pipe
  import lopd_pkg::*;
#(
  parameter int SIZE_DATA = LOPD_SIZE_DATA,
  parameter int SIZE_LOPD = $clog2(SIZE_DATA)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_mode,
  input  logic [SIZE_DATA-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_LOPD-1:0] o_one_position,
  output logic                 o_zero_flag,
  output logic [SIZE_LOPD-1:0] o_shift_amt,
  output logic [SIZE_DATA-1:0] o_norm_data,
  output logic                 o_mode
);

  localparam logic [SIZE_LOPD-1:0] MaxPos = SIZE_LOPD'(SIZE_DATA - 1);

  logic                 en1, en2;
  lopd_mode_e           in_mode;
  logic [SIZE_DATA-1:0] data_rev, enc_in;
  logic [SIZE_LOPD-1:0] enc_pos;
  logic                 enc_zero;

  logic                 s1_valid_q, s1_valid_d;
  logic [SIZE_DATA-1:0] s1_data_q, s1_data_d;
  lopd_mode_e           s1_mode_q, s1_mode_d;
  logic [SIZE_LOPD-1:0] s1_pos_q, s1_pos_d;
  logic                 s1_zero_q, s1_zero_d;

  logic [SIZE_LOPD-1:0] shift_c;
  logic [SIZE_DATA-1:0] norm_c;

  logic                 s2_valid_q, s2_valid_d;
  lopd_mode_e           s2_mode_q, s2_mode_d;
  logic [SIZE_LOPD-1:0] s2_pos_q, s2_pos_d;
  logic                 s2_zero_q, s2_zero_d;
  logic [SIZE_LOPD-1:0] s2_shift_q, s2_shift_d;
  logic [SIZE_DATA-1:0] s2_norm_q, s2_norm_d;

  assign en2     = ~s2_valid_q | i_ready;
  assign en1     = ~s1_valid_q | en2;
  assign o_ready = en1;
  assign in_mode = lopd_mode_e'(i_mode);

  // Trailing-one search reuses the MSB-first encoder on the mirrored word.
  always_comb begin
    data_rev = '0;
    for (int i = 0; i < SIZE_DATA; i++) begin
      data_rev[i] = i_data[SIZE_DATA-1-i];
    end
  end

  assign enc_in = (in_mode == LOPD_TRAIL) ? data_rev : i_data;

  lopd_prio_enc #(
    .SIZE_DATA(SIZE_DATA),
    .SIZE_LOPD(SIZE_LOPD)
  ) u_prio_enc (
    .data_i(enc_in),
    .pos_o (enc_pos),
    .zero_o(enc_zero)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_pos_d   = s1_pos_q;
    s1_zero_d  = s1_zero_q;
    if (en1) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_data_d = i_data;
        s1_mode_d = in_mode;
        s1_zero_d = enc_zero;
        if (enc_zero) begin
          s1_pos_d = '0;
        end else if (in_mode == LOPD_TRAIL) begin
          s1_pos_d = MaxPos - enc_pos;
        end else begin
          s1_pos_d = enc_pos;
        end
      end
    end
  end

  // A zero word leaves shift and norm at 0 regardless of mode.
  always_comb begin
    shift_c = '0;
    norm_c  = '0;
    if (!s1_zero_q) begin
      if (s1_mode_q == LOPD_LEAD) begin
        shift_c = MaxPos - s1_pos_q;
        norm_c  = s1_data_q << shift_c;
      end else begin
        shift_c = s1_pos_q;
        norm_c  = s1_data_q >> shift_c;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_mode_d  = s2_mode_q;
    s2_pos_d   = s2_pos_q;
    s2_zero_d  = s2_zero_q;
    s2_shift_d = s2_shift_q;
    s2_norm_d  = s2_norm_q;
    if (en2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_mode_d  = s1_mode_q;
        s2_pos_d   = s1_pos_q;
        s2_zero_d  = s1_zero_q;
        s2_shift_d = shift_c;
        s2_norm_d  = norm_c;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= LOPD_LEAD;
      s1_pos_q   <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_mode_q  <= LOPD_LEAD;
      s2_pos_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_shift_q <= '0;
      s2_norm_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s1_pos_q   <= s1_pos_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      s2_mode_q  <= s2_mode_d;
      s2_pos_q   <= s2_pos_d;
      s2_zero_q  <= s2_zero_d;
      s2_shift_q <= s2_shift_d;
      s2_norm_q  <= s2_norm_d;
    end
  end

  assign o_valid        = s2_valid_q;
  assign o_mode         = s2_mode_q;
  assign o_one_position = s2_pos_q;
  assign o_zero_flag    = s2_zero_q;
  assign o_shift_amt    = s2_shift_q;
  assign o_norm_data    = s2_norm_q;

endmodule

// File: tb/tb_lopd_norm_pipe.sv
// Self-checking bench for lopd_norm_pipe: constant vector table, hand-written
// corner sequences and a randomized run scored against a shift-loop model.
module tb_lopd_norm_pipe;
  import lopd_pkg::*;

  localparam int W  = 24;
  localparam int LW = 5;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic          o_ready;
  logic          i_mode;
  logic [W-1:0]  i_data;
  logic          o_valid;
  logic          i_ready;
  logic [LW-1:0] o_one_position;
  logic          o_zero_flag;
  logic [LW-1:0] o_shift_amt;
  logic [W-1:0]  o_norm_data;
  logic          o_mode;

  typedef struct {
    logic          mode;
    logic [W-1:0]  data;
    logic [LW-1:0] pos;
    logic          zero;
    logic [LW-1:0] shift;
    logic [W-1:0]  norm;
  } vec_t;

  typedef struct {
    logic          mode;
    logic [LW-1:0] pos;
    logic          zero;
    logic [LW-1:0] shift;
    logic [W-1:0]  norm;
  } res_t;

  int   testsRun    = 0;
  int   testsFailed = 0;
  int   popped      = 0;
  res_t expQ[$];
  logic holdPending = 1'b0;
  res_t heldRes;

  vec_t          vecs[8];
  logic [W-1:0]  bpWords[4];
  logic          bpModes[4];
  int            sent;
  int            popStart;
  int            cyc;
  res_t          snap;
  logic [31:0]   rnd;

  lopd_norm_pipe #(
    .SIZE_DATA(W),
    .SIZE_LOPD(LW)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_mode        (i_mode),
    .i_data        (i_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_one_position(o_one_position),
    .o_zero_flag   (o_zero_flag),
    .o_shift_amt   (o_shift_amt),
    .o_norm_data   (o_norm_data),
    .o_mode        (o_mode)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compareResult(input string name, input res_t act, input res_t exp);
    testsRun++;
    if (act.mode !== exp.mode || act.pos !== exp.pos || act.zero !== exp.zero ||
        act.shift !== exp.shift || act.norm !== exp.norm) begin
      testsFailed++;
      $display("[TB] FAIL %s: got mode=%0d pos=%0d zero=%0d shift=%0d norm=%h, expected mode=%0d pos=%0d zero=%0d shift=%0d norm=%h",
               name, act.mode, act.pos, act.zero, act.shift, act.norm,
               exp.mode, exp.pos, exp.zero, exp.shift, exp.norm);
    end
  endtask

  // Normalise by literally shifting until the wanted end bit is set.
  function automatic res_t refModel(input logic mode, input logic [W-1:0] data);
    res_t         r;
    logic [W-1:0] d;
    int           s;
    d      = data;
    s      = 0;
    r.mode = mode;
    if (data == '0) begin
      r.pos   = '0;
      r.zero  = 1'b1;
      r.shift = '0;
      r.norm  = '0;
    end else begin
      if (mode == 1'b0) begin
        while (d[W-1] == 1'b0) begin
          d = d << 1;
          s++;
        end
        r.pos = LW'(W - 1 - s);
      end else begin
        while (d[0] == 1'b0) begin
          d = d >> 1;
          s++;
        end
        r.pos = LW'(s);
      end
      r.zero  = 1'b0;
      r.shift = LW'(s);
      r.norm  = d;
    end
    return r;
  endfunction

  function automatic res_t currentOut();
    res_t r;
    r.mode  = o_mode;
    r.pos   = o_one_position;
    r.zero  = o_zero_flag;
    r.shift = o_shift_amt;
    r.norm  = o_norm_data;
    return r;
  endfunction

  // Scoreboard: transfers happen on the next rising edge, so sample on the falling one.
  always @(negedge i_clk) begin
    if (i_rst) begin
      expQ.delete();
      holdPending = 1'b0;
    end else begin
      if (holdPending) begin
        checkOutput("holdValid", 32'(o_valid), 32'd1);
        compareResult("holdStable", currentOut(), heldRes);
      end
      if (o_valid && !i_ready) begin
        holdPending = 1'b1;
        heldRes     = currentOut();
      end else begin
        holdPending = 1'b0;
      end
      if (o_valid && i_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedResult", 32'd1, 32'd0);
        end else begin
          compareResult("scoreboard", currentOut(), expQ.pop_front());
          popped++;
        end
      end
      if (i_valid && o_ready) begin
        expQ.push_back(refModel(i_mode, i_data));
      end
    end
  end

  // Single transaction into an empty pipe; checks latency and the tabled result.
  task automatic applyStimulus(input vec_t v);
    int lat;
    bit seen;
    i_ready = 1'b1;
    i_mode  = v.mode;
    i_data  = v.data;
    i_valid = 1'b1;
    checkOutput("readyIdle", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    lat     = 1;
    seen    = 1'b0;
    while (!seen && lat < 10) begin
      if (o_valid) begin
        seen = 1'b1;
      end else begin
        @(posedge i_clk);
        #1;
        lat++;
      end
    end
    checkOutput("latency", 32'(lat), 32'd2);
    checkOutput("vecPos", 32'(o_one_position), 32'(v.pos));
    checkOutput("vecZero", 32'(o_zero_flag), 32'(v.zero));
    checkOutput("vecShift", 32'(o_shift_amt), 32'(v.shift));
    checkOutput("vecNorm", 32'(o_norm_data), 32'(v.norm));
    checkOutput("vecMode", 32'(o_mode), 32'(v.mode));
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 24'h000000, 5'd0,  1'b1, 5'd0,  24'h000000};
    vecs[1] = '{1'b1, 24'h000000, 5'd0,  1'b1, 5'd0,  24'h000000};
    vecs[2] = '{1'b0, 24'h0A0000, 5'd19, 1'b0, 5'd4,  24'hA00000};
    vecs[3] = '{1'b1, 24'h0A0000, 5'd17, 1'b0, 5'd17, 24'h000005};
    vecs[4] = '{1'b0, 24'h000001, 5'd0,  1'b0, 5'd23, 24'h800000};
    vecs[5] = '{1'b1, 24'h800000, 5'd23, 1'b0, 5'd23, 24'h000001};
    vecs[6] = '{1'b0, 24'hFFFFFF, 5'd23, 1'b0, 5'd0,  24'hFFFFFF};
    vecs[7] = '{1'b1, 24'hFFFFFF, 5'd0,  1'b0, 5'd0,  24'hFFFFFF};

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_mode  = 1'b0;
    i_data  = '0;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("resetValid", 32'(o_valid), 32'd0);
    checkOutput("resetNorm", 32'(o_norm_data), 32'd0);
    checkOutput("resetPos", 32'(o_one_position), 32'd0);
    #2;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput("readyAfterReset", 32'(o_ready), 32'd1);

    for (int k = 0; k < 8; k++) begin
      applyStimulus(vecs[k]);
    end

    // One-hot sweep: results must follow back to back, two cycles behind the inputs.
    i_ready = 1'b1;
    for (int c = 0; c < 26; c++) begin
      if (c < 24) begin
        i_valid = 1'b1;
        i_mode  = 1'b0;
        i_data  = W'(1) << c;
      end else begin
        i_valid = 1'b0;
      end
      if (c >= 2) begin
        checkOutput("sweepValid", 32'(o_valid), 32'd1);
        checkOutput("sweepPos", 32'(o_one_position), 32'(c - 2));
        checkOutput("sweepShift", 32'(o_shift_amt), 32'(25 - c));
        checkOutput("sweepNorm", 32'(o_norm_data), 32'h800000);
        checkOutput("sweepZero", 32'(o_zero_flag), 32'd0);
      end
      @(posedge i_clk);
      #1;
    end

    // Backpressure: downstream stalls for cycles 2-4 with both stages full.
    for (int k = 0; k < 4; k++) begin
      rnd        = $urandom();
      bpWords[k] = rnd[W-1:0] | W'(1);
      bpModes[k] = 1'($urandom_range(0, 1));
    end
    sent     = 0;
    popStart = popped;
    for (int c = 0; c < 14; c++) begin
      i_ready = !(c >= 2 && c <= 4);
      if (sent < 4) begin
        i_valid = 1'b1;
        i_data  = bpWords[sent];
        i_mode  = bpModes[sent];
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (c == 2) begin
        checkOutput("bpReadyFull", 32'(o_ready), 32'd0);
        checkOutput("bpValidFull", 32'(o_valid), 32'd1);
        snap = currentOut();
      end
      if (c == 3 || c == 4) begin
        compareResult("bpHold", currentOut(), snap);
      end
      if (i_valid && o_ready) begin
        sent++;
      end
      @(posedge i_clk);
      #1;
    end
    checkOutput("bpAllSent", 32'(sent), 32'd4);
    checkOutput("bpResultCount", 32'(popped - popStart), 32'd4);
    checkOutput("bpQueueEmpty", 32'(expQ.size()), 32'd0);

    // Asynchronous reset with two items in flight.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_mode  = 1'b0;
    i_data  = 24'h123456;
    @(posedge i_clk);
    #1;
    i_data = 24'h00F000;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    checkOutput("rstPreValid", 32'(o_valid), 32'd1);
    checkOutput("rstPreReady", 32'(o_ready), 32'd0);
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("rstValid", 32'(o_valid), 32'd0);
    checkOutput("rstPos", 32'(o_one_position), 32'd0);
    checkOutput("rstShift", 32'(o_shift_amt), 32'd0);
    checkOutput("rstNorm", 32'(o_norm_data), 32'd0);
    checkOutput("rstZero", 32'(o_zero_flag), 32'd0);
    checkOutput("rstMode", 32'(o_mode), 32'd0);
    #3;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput("rstReady", 32'(o_ready), 32'd1);
    applyStimulus(vecs[3]);

    // Randomized traffic with random backpressure, scored by the negedge monitor.
    sent     = 0;
    cyc      = 0;
    popStart = popped;
    while (sent < 1000 && cyc < 20000) begin
      i_ready = ($urandom_range(0, 9) < 7);
      i_valid = ($urandom_range(0, 9) < 8);
      i_mode  = 1'($urandom_range(0, 1));
      rnd     = $urandom();
      rnd     = rnd >> $urandom_range(0, 31);
      rnd     = rnd << $urandom_range(0, 23);
      i_data  = rnd[W-1:0];
      if ($urandom_range(0, 19) == 0) begin
        i_data = '0;
      end
      #1;
      if (i_valid && o_ready) begin
        sent++;
      end
      @(posedge i_clk);
      #1;
      cyc++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    checkOutput("randSent", 32'(sent), 32'd1000);
    checkOutput("randResultCount", 32'(popped - popStart), 32'd1000);
    checkOutput("randQueueEmpty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
